// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and helpers for the 16-bit pipeline
//
// Contents:
//   WORD_W      datapath/instruction width
//   RESET_PC    program counter value after reset
//   NOP_INSTR   bubble encoding written into pipeline registers
//   OPC_MSB/LSB opcode field position within an instruction
//   OPC_JUMP    opcode of the unconditional jump
//   INSTR_STEP  byte distance between sequential instructions
//   jump_target PC-relative target of a jump given the jump's PC+2
package fetch_stage_pkg;

    localparam int          WORD_W     = 16;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam int          OPC_MSB    = 15;
    localparam int          OPC_LSB    = 12;
    localparam logic [3:0]  OPC_JUMP   = 4'h3;
    localparam logic [15:0] INSTR_STEP = 16'd2;

    // The 12-bit offset counts instructions, so it is doubled to bytes and
    // sign-extended; the add wraps modulo 2^16 like all PC arithmetic.
    function automatic logic [WORD_W-1:0] jump_target(
        input logic [WORD_W-1:0] pc_plus2,
        input logic [WORD_W-1:0] instr
    );
        jump_target = pc_plus2 + {{3{instr[11]}}, instr[11:0], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory, controls, IF/ID outputs
//
// Signals:
//   imem_addr     instruction memory read address (PC)
//   imem_instr    instruction at imem_addr, same cycle
//   stall         hold PC and IF/ID
//   flush         squash IF/ID to a bubble
//   redirect      taken branch/jump resolved downstream
//   redirect_pc   target PC for redirect
//   ifid_instr    registered instruction
//   ifid_pc_plus2 registered PC+2 of that instruction
//   ifid_valid    IF/ID holds a real instruction
//   early_jump    pulse when IF redirected itself on a jump
// Modports: master = fetch stage, slave = memory / hazard / decode side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_instr;
    logic              stall;
    logic              flush;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_pc_plus2;
    logic              ifid_valid;
    logic              early_jump;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_pc,
        output ifid_instr,
        output ifid_pc_plus2,
        output ifid_valid,
        output early_jump
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output flush,
        output redirect,
        output redirect_pc,
        input  ifid_instr,
        input  ifid_pc_plus2,
        input  ifid_valid,
        input  early_jump
    );

endinterface

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - pipeline register holding instr, pc_plus2 and valid
//
// Ports:
//   clk          pipeline clock
//   rst          asynchronous active-low reset (clears to bubble)
//   bubble       write a bubble (highest priority)
//   load         capture instr_d/pc_plus2_d and mark valid; hold when low
//   instr_d      incoming instruction
//   pc_plus2_d   incoming PC+2
//   instr_q      registered instruction
//   pc_plus2_q   registered PC+2
//   valid_q      register holds a real instruction
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              load,
    input  logic [WORD_W-1:0] instr_d,
    input  logic [WORD_W-1:0] pc_plus2_d,
    output logic [WORD_W-1:0] instr_q,
    output logic [WORD_W-1:0] pc_plus2_q,
    output logic              valid_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (bubble) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (load) begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, next-PC mux and IF/ID register
//
// Ports:
//   clk  pipeline clock
//   rst  asynchronous active-low reset
//   bus  fetch_stage_if.master (imem, stall/flush/redirect, IF/ID outputs)
// Build option: FETCH_EARLY_JUMP_EN resolves unconditional jumps in IF with
// zero penalty; otherwise jumps flow downstream and early_jump is tied 0.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus2;
    logic [WORD_W-1:0] pc_next;
    logic              take_jump;
    logic              ifid_bubble;

    assign pc_plus2      = pc + INSTR_STEP;
    assign bus.imem_addr = pc;

`ifdef FETCH_EARLY_JUMP_EN
    logic [WORD_W-1:0] jump_pc;

    assign jump_pc   = jump_target(pc_plus2, bus.imem_instr);
    // A downstream redirect or a stall means this fetch is not consumed now,
    // so the jump must not be acted on this cycle.
    assign take_jump = (bus.imem_instr[OPC_MSB:OPC_LSB] == OPC_JUMP)
                       && !bus.redirect && !bus.stall;
`else
    assign take_jump = 1'b0;
`endif

    assign bus.early_jump = take_jump;

    always_comb begin
        pc_next = pc_plus2;
        if (bus.redirect) begin
            pc_next = {bus.redirect_pc[WORD_W-1:1], 1'b0};
        end else if (bus.stall) begin
            pc_next = pc;
`ifdef FETCH_EARLY_JUMP_EN
        end else if (take_jump) begin
            pc_next = jump_pc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // A jump taken in IF is consumed here, so it is replaced by a bubble.
    assign ifid_bubble = bus.redirect || bus.flush || take_jump;

    if_id_register u_if_id (
        .clk        (clk),
        .rst        (rst),
        .bubble     (ifid_bubble),
        .load       (!bus.stall),
        .instr_d    (bus.imem_instr),
        .pc_plus2_d (pc_plus2),
        .instr_q    (bus.ifid_instr),
        .pc_plus2_q (bus.ifid_pc_plus2),
        .valid_q    (bus.ifid_valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage, 16-bit pipelined datapath. It owns the program counter, drives the instruction memory read address, and captures the returned instruction into the IF/ID pipeline register. It accepts stall, flush and redirect controls from the hazard unit and the branch/jump resolution logic. Optionally, it resolves unconditional jumps in IF.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding written into IF/ID on reset or flush.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  16  current PC; drives the instruction memory read address (combinational memory read).
- imem_instr  in  16  instruction at imem_addr, valid in the same cycle.
- stall  in  1  hazard-unit stall; holds the PC and IF/ID.
- flush  in  1  squashes IF/ID to a bubble.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  target PC for redirect.
- ifid_instr  out  16  registered instruction.
- ifid_pc_plus2  out  16  registered PC+2 of that instruction, used for branch-target arithmetic.
- ifid_valid  out  1  IF/ID holds a real instruction.
- early_jump  out  1  single-cycle pulse when IF redirected on a jump; tied 0 without the macro.

## Operation
- PC and all IF/ID outputs are registers. imem_addr = PC.
- Instructions are 16 bits at even byte addresses, so the sequential step is PC+2.
- All PC arithmetic is 16-bit modulo (16'hFFFE + 2 = 16'h0000).
- redirect_pc[0] is forced to 0 when loaded.

Next-PC priority, highest first:
1. redirect → redirect_pc
2. stall → hold
3. early jump (macro only) → jump target
4. otherwise → PC+2

Next IF/ID state, highest first:
1. redirect or flush → bubble: ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc_plus2 = 0.
2. stall → hold all three outputs.
3. otherwise → ifid_instr = imem_instr, ifid_pc_plus2 = PC+2, ifid_valid = 1.

Boundary conditions:
- stall with flush: the bubble is written and the PC holds.
- stall with redirect: redirect wins for both the PC and IF/ID.
- Reset mid-operation clears everything asynchronously. The previous PC is not retained.

## Timing
- Reset values: PC = RESET_PC, so imem_addr = RESET_PC; ifid_instr = NOP_INSTR; ifid_pc_plus2 = 0; ifid_valid = 0; early_jump = 0.
- First rising edge after rst deasserts: captures the instruction at RESET_PC, and ifid_valid goes to 1.
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect penalty:
  - Cycle N: redirect is sampled.
  - Edge N+1: PC = target, IF/ID becomes a bubble.
  - Edge N+2: the target instruction is in IF/ID.
- Stall held for k cycles freezes the PC and IF/ID for exactly k edges. There is no lost or duplicated fetch.
- early_jump is asserted combinationally in the cycle the jump is at imem_addr and the PC is not stalled or redirected.

## Configuration
Macro: FETCH_EARLY_JUMP_EN.

- Defined:
  - When imem_instr[15:12] == 4'h3 (jump) and neither redirect nor stall is asserted, the next PC is PC + 2 + (sign-extended imem_instr[11:0] << 1), 16-bit wrap.
  - IF/ID receives a bubble instead of the jump, so downstream never resolves it.
  - early_jump pulses for that cycle.
  - Jump penalty: 0 cycles.
- Undefined:
  - The jump passes through IF/ID as an ordinary instruction with ifid_valid = 1.
  - early_jump is constant 0.
  - The jump is resolved downstream via redirect.

## Structure
- Shared pipeline package contents:
  - 16-bit word width constant
  - NOP_INSTR default
  - opcode field position [15:12]
  - OPC_JUMP = 4'h3
  - instruction step constant (2)
- Sub-module if_id_register: holds instr, pc_plus2 and valid, with load/hold/bubble controls and asynchronous active-low reset. It is reusable for later pipeline registers.
- PC logic and next-PC mux stay in fetch_stage.

## Test plan
- Reset, then release; memory holds 16'h1010 at 0 and 2 → IF/ID shows 1010/pc_plus2 2/valid 1, then 1010/4; imem_addr sequence 0, 2, 4.
- Stall held 3 cycles with PC = 4 → imem_addr stays 4 and IF/ID holds its contents; the first edge after release captures the instruction at 4.
- redirect = 1 with redirect_pc = 16'h000A at PC = 2 → next edge PC = 000A and IF/ID is a bubble (valid 0, instr 0000); the following edge captures the instruction at 000A.
- Simultaneous redirect, stall and flush → redirect wins (PC = target, bubble); stall with flush only → bubble, PC holds; redirect_pc = 16'h0007 → PC = 16'h0006.
- FETCH_EARLY_JUMP_EN, instruction 16'h3004 at 0 → early_jump pulses, next PC = 000A, IF/ID bubble. Without the macro → 3004 enters IF/ID with valid 1 and PC = 2.
- PC = 16'hFFFE without stall → next PC = 0000; asserting rst mid-run at PC = 0x0010 → immediate PC = RESET_PC and ifid_valid = 0.
